// File: rtl/mem_port_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single block-wide RAM port.
// Default policy is fixed priority (DC wins); define ARB_ROUND_ROBIN_EN for round-robin.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 30,
    parameter int BLOCK_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ic_req,
    input  logic [ADDR_WIDTH-1:0]  ic_addr,
    input  logic                   dc_req,
    input  logic                   dc_we,
    input  logic [ADDR_WIDTH-1:0]  dc_addr,
    input  logic [BLOCK_WIDTH-1:0] dc_wdata,
    input  logic                   ram_ready,
    input  logic [BLOCK_WIDTH-1:0] ram_rdata,
    output logic                   ram_en,
    output logic                   ram_write,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [BLOCK_WIDTH-1:0] ram_wdata,
    output logic                   ic_ack,
    output logic                   dc_ack,
    output logic [BLOCK_WIDTH-1:0] rdata_out,
    output logic                   busy,
    output logic [1:0]             grant_id
);

    // state        | meaning
    // S_IDLE       | no transfer, arbitrating pending requests
    // S_IC_XFER    | I-cache refill in flight, waiting for ram_ready
    // S_DC_RD_XFER | D-cache refill in flight, waiting for ram_ready
    // S_DC_WB_XFER | D-cache writeback in flight, waiting for ram_ready
    // S_DONE       | one-cycle ack to the granted requester
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_IC_XFER    = 3'd1,
        S_DC_RD_XFER = 3'd2,
        S_DC_WB_XFER = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'd0;
    localparam logic [1:0] GRANT_IC    = 2'd1;
    localparam logic [1:0] GRANT_DC_RD = 2'd2;
    localparam logic [1:0] GRANT_DC_WB = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] grant_q;
    logic       pick_dc;
    logic       grant_dc;
    logic       grant_ic;
    logic       xfer_read;

    assign grant_dc  = (state_q == S_IDLE) && pick_dc;
    assign grant_ic  = (state_q == S_IDLE) && ic_req && !pick_dc;
    assign xfer_read = (state_q == S_IC_XFER) || (state_q == S_DC_RD_XFER);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ic_q;

    // Pointer starts on IC so the first contested grant goes to DC.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ic_q <= 1'b1;
        end else if (grant_dc) begin
            last_ic_q <= 1'b0;
        end else if (grant_ic) begin
            last_ic_q <= 1'b1;
        end
    end

    assign pick_dc = dc_req && (!ic_req || last_ic_q);
`else
    assign pick_dc = dc_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_dc) begin
                    state_d = dc_we ? S_DC_WB_XFER : S_DC_RD_XFER;
                end else if (grant_ic) begin
                    state_d = S_IC_XFER;
                end
            end
            S_IC_XFER, S_DC_RD_XFER, S_DC_WB_XFER: begin
                if (ram_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_write = 1'b0;
        busy      = 1'b0;
        grant_id  = GRANT_NONE;
        ic_ack    = 1'b0;
        dc_ack    = 1'b0;
        case (state_q)
            S_IC_XFER: begin
                ram_en   = 1'b1;
                busy     = 1'b1;
                grant_id = GRANT_IC;
            end
            S_DC_RD_XFER: begin
                ram_en   = 1'b1;
                busy     = 1'b1;
                grant_id = GRANT_DC_RD;
            end
            S_DC_WB_XFER: begin
                ram_en    = 1'b1;
                ram_write = 1'b1;
                busy      = 1'b1;
                grant_id  = GRANT_DC_WB;
            end
            S_DONE: begin
                busy     = 1'b1;
                grant_id = grant_q;
                ic_ack   = (grant_q == GRANT_IC);
                dc_ack   = (grant_q == GRANT_DC_RD) || (grant_q == GRANT_DC_WB);
            end
            default: ;
        endcase
    end

    // Request fields are captured only at grant, so later input changes are invisible to the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            rdata_out <= '0;
            grant_q   <= GRANT_NONE;
        end else begin
            if (grant_dc) begin
                ram_addr <= dc_addr;
                grant_q  <= dc_we ? GRANT_DC_WB : GRANT_DC_RD;
                if (dc_we) begin
                    ram_wdata <= dc_wdata;
                end
            end else if (grant_ic) begin
                ram_addr <= ic_addr;
                grant_q  <= GRANT_IC;
            end
            if (ram_ready && xfer_read) begin
                rdata_out <= ram_rdata;
            end
        end
    end

endmodule
